graphic_eq_gain_mixer: RTL and testbench

//  Parametrised per-band gain/mix stage for the graphic equaliser; replaces fixed 3-band, 2-instance EQ control.

---
 rtl/graphic_eq_gain_mixer.sv | 240 ++++++++++++++++++++++++
 tb/tb_graphic_eq_gain_mixer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/graphic_eq_gain_mixer.sv
// graphic_eq_gain_mixer
// Per-band gain stage for the graphic equaliser. Band levels are captured on a
// rising edge of 'set', ramped one LSB per frame toward the captured target, and
// each channel's bands are gain-weighted and summed with saturation through a
// single time-shared multiply-accumulate.
module graphic_eq_gain_mixer #(
    parameter int NUM_CH    = 2,
    parameter int NUM_BANDS = 4,
    parameter int DATA_W    = 32,
    parameter int LVL_W     = 5
) (
    input  logic                                CLOCK_50,
    input  logic                                reset,
    input  logic                                set,
    input  logic [NUM_BANDS*LVL_W-1:0]          band_level,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_CH*NUM_BANDS*DATA_W-1:0]  band_in,
    output logic                                out_valid,
    output logic [NUM_CH*DATA_W-1:0]            out_data
);

    localparam int NUM_SMP = NUM_CH * NUM_BANDS;
    localparam int IDX_W   = $clog2(NUM_SMP);
    localparam int BAND_W  = $clog2(NUM_BANDS);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W  = DATA_W + LVL_W + 1;
    localparam int ACC_W   = DATA_W + LVL_W + $clog2(NUM_BANDS) + 1;
    localparam int SHIFT   = LVL_W - 1;

    localparam logic [BAND_W-1:0]       BAND_LAST = BAND_W'(NUM_BANDS - 1);
    localparam logic [CH_W-1:0]         CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic signed [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_MAX   = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN   = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_MAC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Level L maps to gain 2^(LVL_W-1)+L; adding the offset is an MSB flip.
    function automatic logic [LVL_W-1:0] level_to_gain(input logic signed [LVL_W-1:0] level);
        level_to_gain = {~level[LVL_W-1], level[LVL_W-2:0]};
    endfunction

    // One LSB toward the target, never past it.
    function automatic logic signed [LVL_W-1:0] ramp_step(input logic signed [LVL_W-1:0] cur,
                                                          input logic signed [LVL_W-1:0] tgt);
        if (cur < tgt) begin
            ramp_step = cur + LVL_ONE;
        end else if (cur > tgt) begin
            ramp_step = cur - LVL_ONE;
        end else begin
            ramp_step = cur;
        end
    endfunction

    // Remove the gain scaling and clamp to the sample range.
    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> SHIFT;
        if (shifted > ACC_MAX) begin
            saturate = ACC_MAX[DATA_W-1:0];
        end else if (shifted < ACC_MIN) begin
            saturate = ACC_MIN[DATA_W-1:0];
        end else begin
            saturate = shifted[DATA_W-1:0];
        end
    endfunction

    state_t                    state_r;
    state_t                    next_state_s;
    logic                      set_r;
    logic                      set_d_r;
    logic signed [LVL_W-1:0]   target_r  [NUM_BANDS];
    logic signed [LVL_W-1:0]   current_r [NUM_BANDS];
    logic signed [LVL_W-1:0]   snap_r    [NUM_BANDS];
    logic signed [DATA_W-1:0]  smp_r     [NUM_SMP];
    logic signed [DATA_W-1:0]  res_r     [NUM_CH];
    logic [BAND_W-1:0]         band_idx_r;
    logic [CH_W-1:0]           ch_idx_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic                      in_ready_r;
    logic                      out_valid_r;
    logic [NUM_CH*DATA_W-1:0]  out_data_r;

    logic [IDX_W-1:0]          smp_idx_s;
    logic signed [DATA_W-1:0]  mac_smp_s;
    logic signed [LVL_W:0]     mac_gain_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   acc_base_s;
    logic signed [ACC_W-1:0]   acc_next_s;
    logic                      mac_last_s;

    // Next-state logic for the frame sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    next_state_s = ST_RAMP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RAMP: next_state_s = ST_MAC;
            ST_MAC: begin
                if (mac_last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_MAC;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Edge-detect the set request and capture target levels, in any state.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            set_r   <= 1'b0;
            set_d_r <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                target_r[b] <= '0;
            end
        end else begin
            set_r   <= set;
            set_d_r <= set_r;
            if (set_r && !set_d_r) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    target_r[b] <= band_level[b*LVL_W +: LVL_W];
                end
            end
        end
    end

    // Step current levels once per frame; the new values apply to the next frame.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                current_r[b] <= '0;
            end
        end else if (state_r == ST_RAMP) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                current_r[b] <= ramp_step(current_r[b], target_r[b]);
            end
        end
    end

    // Select the operand pair for the current MAC step and form the next accumulator.
    always_comb begin
        smp_idx_s  = IDX_W'(ch_idx_r) * IDX_W'(NUM_BANDS) + IDX_W'(band_idx_r);
        mac_smp_s  = smp_r[smp_idx_s];
        mac_gain_s = $signed({1'b0, level_to_gain(snap_r[band_idx_r])});
        prod_s     = PROD_W'(mac_smp_s) * PROD_W'(mac_gain_s);
        acc_base_s = (band_idx_r == '0) ? '0 : acc_r;
        acc_next_s = acc_base_s + ACC_W'(prod_s);
        mac_last_s = (band_idx_r == BAND_LAST) && (ch_idx_r == CH_LAST);
    end

    // Frame capture, gain snapshot and the time-shared accumulate.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SMP; i++) begin
                smp_r[i] <= '0;
            end
            for (int b = 0; b < NUM_BANDS; b++) begin
                snap_r[b] <= '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                res_r[c] <= '0;
            end
            band_idx_r <= '0;
            ch_idx_r   <= '0;
            acc_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_SMP; i++) begin
                            smp_r[i] <= band_in[i*DATA_W +: DATA_W];
                        end
                        for (int b = 0; b < NUM_BANDS; b++) begin
                            snap_r[b] <= current_r[b];
                        end
                        band_idx_r <= '0;
                        ch_idx_r   <= '0;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_next_s;
                    if (band_idx_r == BAND_LAST) begin
                        res_r[ch_idx_r] <= saturate(acc_next_s);
                        band_idx_r      <= '0;
                        ch_idx_r        <= ch_idx_r + CH_W'(1);
                    end else begin
                        band_idx_r <= band_idx_r + BAND_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered handshake and result outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            in_ready_r  <= (next_state_s == ST_IDLE);
            out_valid_r <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    out_data_r[c*DATA_W +: DATA_W] <= res_r[c];
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_graphic_eq_gain_mixer.sv
// Scoreboard bench for graphic_eq_gain_mixer: stimulus pushes hand-computed
// expected outputs with their accept cycle; a negedge monitor pops and compares.
module tb_graphic_eq_gain_mixer;

    localparam int NUM_CH    = 2;
    localparam int NUM_BANDS = 4;
    localparam int DATA_W    = 32;
    localparam int LVL_W     = 5;
    localparam int NUM_SMP   = NUM_CH * NUM_BANDS;
    localparam int LATENCY   = NUM_CH * NUM_BANDS + 2;

    logic                               clk = 1'b0;
    logic                               reset;
    logic                               set;
    logic [NUM_BANDS*LVL_W-1:0]         band_level;
    logic                               in_valid;
    logic                               in_ready;
    logic [NUM_CH*NUM_BANDS*DATA_W-1:0] band_in;
    logic                               out_valid;
    logic [NUM_CH*DATA_W-1:0]           out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_accept = 0;

    logic [NUM_CH*DATA_W-1:0] exp_q [$];
    int                       cyc_q [$];
    logic [NUM_CH*DATA_W-1:0] mon_exp;
    int                       mon_cyc;
    logic [DATA_W-1:0]        smp [NUM_SMP];

    graphic_eq_gain_mixer #(
        .NUM_CH(NUM_CH), .NUM_BANDS(NUM_BANDS), .DATA_W(DATA_W), .LVL_W(LVL_W)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .set       (set),
        .band_level(band_level),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .band_in   (band_in),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every out_valid must match the oldest expected frame, at the right latency.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: out_data=%h with no frame pending (cycle %0d)", out_data, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = cyc_q.pop_front();
                checks++;
                if (out_data !== mon_exp) begin
                    errors++;
                    $display("FAIL out_data: got %h required %h (cycle %0d)", out_data, mon_exp, cyc);
                end
                checks++;
                if (cyc - mon_cyc != LATENCY) begin
                    errors++;
                    $display("FAIL latency: got %0d required %0d", cyc - mon_cyc, LATENCY);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [NUM_BANDS*LVL_W-1:0] levels(input int l0, input int l1,
                                                         input int l2, input int l3);
        logic [LVL_W-1:0] a0, a1, a2, a3;
        a0 = LVL_W'(l0);
        a1 = LVL_W'(l1);
        a2 = LVL_W'(l2);
        a3 = LVL_W'(l3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input logic [NUM_CH*DATA_W-1:0] got,
                         input logic [NUM_CH*DATA_W-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic set_all(input logic [DATA_W-1:0] ch0, input logic [DATA_W-1:0] ch1);
        for (int i = 0; i < NUM_BANDS; i++) begin
            smp[i]             = ch0;
            smp[NUM_BANDS + i] = ch1;
        end
    endtask

    // Present smp[] until accepted; optionally record the expected output.
    task automatic send_frame(input bit expect_out, input logic [DATA_W-1:0] e0,
                              input logic [DATA_W-1:0] e1, input bit keep_valid);
        int waited;
        @(negedge clk);
        for (int i = 0; i < NUM_SMP; i++) begin
            band_in[i*DATA_W +: DATA_W] = smp[i];
        end
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end else begin
            if (expect_out) begin
                exp_q.push_back({e1, e0});
                cyc_q.push_back(cyc + 1);
            end
            last_accept = cyc + 1;
        end
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic pulse_set(input logic [NUM_BANDS*LVL_W-1:0] lv);
        @(negedge clk);
        band_level = lv;
        set = 1'b1;
        repeat (2) @(negedge clk);
        set = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d frames outstanding required 0", exp_q.size());
        end
    endtask

    initial begin
        int prev;
        reset      = 1'b0;
        set        = 1'b0;
        band_level = '0;
        in_valid   = 1'b0;
        band_in    = '0;
        set_all(32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Unity gain: plain per-channel sums.
        set_all(32'd100, 32'd100);
        send_frame(1'b1, 32'd400, 32'd400, 1'b0);
        smp[0] = 32'd1; smp[1] = 32'd2; smp[2] = 32'd3; smp[3] = 32'd4;
        smp[4] = -32'sd5; smp[5] = -32'sd6; smp[6] = 32'd7; smp[7] = 32'd100;
        send_frame(1'b1, 32'd10, 32'd96, 1'b0);
        drain();

        // Band0 ramps to mute: 1000*(16-n)/16, then 0; ch1 band1 untouched.
        pulse_set(levels(-16, 0, 0, 0));
        set_all(32'd0, 32'd0);
        smp[0] = 32'd1000;
        smp[5] = 32'd50;
        for (int n = 0; n <= 16; n++) begin
            send_frame(1'b1, DATA_W'((1000 * (16 - n)) / 16), 32'd50, 1'b0);
        end
        drain();

        // Reset during MAC: no output, cleared state, unity levels afterwards.
        set_all(32'd100, 32'd100);
        send_frame(1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", out_data, 64'd0);
        repeat (14) @(negedge clk);
        send_frame(1'b1, 32'd400, 32'd400, 1'b0);
        drain();

        // set during MAC: current frame unaffected, band1 gain then 16..24/16 and holds.
        set_all(32'd0, 32'd0);
        smp[1] = 32'd160;
        smp[5] = -32'sd160;
        band_level = levels(0, 8, 0, 0);
        send_frame(1'b1, 32'd160, -32'sd160, 1'b0);
        repeat (2) @(negedge clk);
        set = 1'b1;
        repeat (2) @(negedge clk);
        set = 1'b0;
        for (int n = 0; n < 10; n++) begin
            send_frame(1'b1, DATA_W'(10 * ((16 + n > 24) ? 24 : 16 + n)),
                       DATA_W'(-10 * ((16 + n > 24) ? 24 : 16 + n)), 1'b0);
        end
        drain();

        // Boost to +15 on every band: band0 gain climbs 16..31, then saturation.
        pulse_set(levels(15, 15, 15, 15));
        set_all(32'd0, 32'd0);
        smp[0] = 32'd16;
        for (int n = 0; n < 16; n++) begin
            send_frame(1'b1, DATA_W'(16 + n), 32'd0, 1'b0);
        end
        set_all(32'h7FFF_FFF0, 32'h8000_0010);
        send_frame(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        set_all(32'd0, 32'd0);
        smp[0] = -32'sd3;
        smp[6] = 32'd32;
        send_frame(1'b1, -32'sd6, 32'd62, 1'b0);
        drain();

        // in_valid held high: accepts every LATENCY+1 cycles, one output each.
        set_all(32'd16, -32'sd16);
        send_frame(1'b1, 32'd124, -32'sd124, 1'b1);
        for (int f = 2; f <= 3; f++) begin
            prev = last_accept;
            set_all(DATA_W'(16 * f), DATA_W'(-16 * f));
            send_frame(1'b1, DATA_W'(124 * f), DATA_W'(-124 * f), f != 3);
            check("accept_interval", 64'(last_accept - prev), 64'(LATENCY + 1));
        end
        drain();
        repeat (15) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
